light_seq_checker: RTL and testbench

Passive monitor on the traffic-light output bus (`red`, `amber`, `green`). It samples the three lamp signals every clock and checks them against the legal UK sequence R → R+A → G → A → R. It reports the first violation with a sticky flag and code, and counts completed cycles and errors. It sits alongside the `light` controller in system builds and in benches, as the consumer end of the same lamp interface.

---
 rtl/light_seq_checker.sv | 228 ++++++++++++++++++++++
 tb/tb_light_seq_checker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/light_seq_checker.sv
// ============================================================================
//  Module   : light_seq_checker
//  Purpose  : Passive monitor for a UK traffic-light lamp bus. Samples the
//             red/amber/green lamps every clock, tracks the legal sequence
//             R -> R+A -> G -> A -> R, flags the first violation with a
//             sticky code, and keeps saturating counts of completed
//             sequences and of violations.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MAX_HOLD  extra consecutive repeats of a pattern allowed before a hold
//              violation (0 = the pattern must change every clock)
//    CNT_W     width of err_cnt and seq_cnt
//  Ports
//    clk       in   rising-edge clock
//    rst       in   asynchronous reset, active low
//    red       in   red lamp
//    amber     in   amber lamp
//    green     in   green lamp
//    clr       in   synchronous clear of error state and counters
//    locked    out  checker synchronised to a legal pattern
//    err       out  sticky violation flag
//    err_code  out  first violation: 00 none, 01 illegal pattern,
//                   10 illegal transition, 11 hold overflow
//    err_cnt   out  saturating violation count
//    seq_done  out  one-cycle pulse on A -> R
//    seq_cnt   out  saturating count of seq_done pulses
//  Build option
//    LIGHT_CHK_HOLD_EN  when defined, repeated patterns are limited by
//                       MAX_HOLD and code 11 can be raised; otherwise
//                       repeats are always legal.
// ============================================================================
`default_nettype none

module light_seq_checker #(
   parameter int MAX_HOLD = 0,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             red,
   input  logic             amber,
   input  logic             green,
   input  logic             clr,
   output logic             locked,
   output logic             err,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] err_cnt,
   output logic             seq_done,
   output logic [CNT_W-1:0] seq_cnt
);

   typedef enum logic [2:0] {
      ST_UNSYNC = 3'd0,
      ST_R      = 3'd1,
      ST_RA     = 3'd2,
      ST_G      = 3'd3,
      ST_A      = 3'd4
   } state_t;

   localparam logic [1:0]       CODE_PAT   = 2'b01;
   localparam logic [1:0]       CODE_TRANS = 2'b10;
   localparam logic [1:0]       CODE_HOLD  = 2'b11;
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t             state_q, state_d;
   logic               locked_q;
   logic               err_q, err_d;
   logic [1:0]         code_q, code_d;
   logic [CNT_W-1:0]   ecnt_q, ecnt_d;
   logic [CNT_W-1:0]   scnt_q, scnt_d;
   logic               done_q;

   logic [2:0]         pat;
   logic               pat_legal;
   state_t             pat_state;
   state_t             nxt_state;
   logic               viol;
   logic [1:0]         viol_code;
   logic               done;

`ifdef LIGHT_CHK_HOLD_EN
   localparam int              HOLD_W   = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
   logic [HOLD_W-1:0] hold_q, hold_d;
`else
   // MAX_HOLD has no effect when hold checking is compiled out
   logic unused_max_hold;
   assign unused_max_hold = (MAX_HOLD != 0);
`endif

   // Map the sampled lamp pattern onto the state it represents
   always_comb begin
      pat       = {red, amber, green};
      pat_legal = 1'b1;
      pat_state = ST_UNSYNC;
      case (pat)
         3'b100:  pat_state = ST_R;
         3'b110:  pat_state = ST_RA;
         3'b001:  pat_state = ST_G;
         3'b010:  pat_state = ST_A;
         default: pat_legal = 1'b0;
      endcase
   end

   always_comb begin
      nxt_state = ST_UNSYNC;
      case (state_q)
         ST_R:    nxt_state = ST_RA;
         ST_RA:   nxt_state = ST_G;
         ST_G:    nxt_state = ST_A;
         ST_A:    nxt_state = ST_R;
         default: nxt_state = ST_UNSYNC;
      endcase
   end

   // Sequence tracking: next state and violation detection
   always_comb begin
      state_d   = state_q;
      viol      = 1'b0;
      viol_code = 2'b00;
      done      = 1'b0;
`ifdef LIGHT_CHK_HOLD_EN
      hold_d    = hold_q;
`endif
      if (state_q == ST_UNSYNC) begin
         if (pat_legal) begin
            state_d = pat_state;
`ifdef LIGHT_CHK_HOLD_EN
            hold_d  = '0;
`endif
         end else begin
            viol      = 1'b1;
            viol_code = CODE_PAT;
         end
      end else if (!pat_legal) begin
         viol      = 1'b1;
         viol_code = CODE_PAT;
         state_d   = ST_UNSYNC;
      end else if (pat_state == nxt_state) begin
         state_d = pat_state;
         done    = (state_q == ST_A);
`ifdef LIGHT_CHK_HOLD_EN
         hold_d  = '0;
`endif
      end else if (pat_state == state_q) begin
`ifdef LIGHT_CHK_HOLD_EN
         // At the limit the counter is frozen, so every further repeat
         // is reported again
         if (hold_q == HOLD_LIM) begin
            viol      = 1'b1;
            viol_code = CODE_HOLD;
         end else begin
            hold_d = hold_q + HOLD_ONE;
         end
`endif
      end else begin
         viol      = 1'b1;
         viol_code = CODE_TRANS;
         state_d   = pat_state;
`ifdef LIGHT_CHK_HOLD_EN
         hold_d    = '0;
`endif
      end
   end

   // Error and counter update: clear first, then apply this cycle's events
   always_comb begin
      err_d  = clr ? 1'b0  : err_q;
      code_d = clr ? 2'b00 : code_q;
      ecnt_d = clr ? '0    : ecnt_q;
      scnt_d = clr ? '0    : scnt_q;
      if (viol) begin
         err_d = 1'b1;
         if (code_d == 2'b00) begin
            code_d = viol_code;
         end
         if (ecnt_d != CNT_MAX) begin
            ecnt_d = ecnt_d + CNT_ONE;
         end
      end
      if (done && (scnt_d != CNT_MAX)) begin
         scnt_d = scnt_d + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_UNSYNC;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         code_q   <= 2'b00;
         ecnt_q   <= '0;
         scnt_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         locked_q <= (state_d != ST_UNSYNC);
         err_q    <= err_d;
         code_q   <= code_d;
         ecnt_q   <= ecnt_d;
         scnt_q   <= scnt_d;
         done_q   <= done;
      end
   end

`ifdef LIGHT_CHK_HOLD_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end
`endif

   assign locked   = locked_q;
   assign err      = err_q;
   assign err_code = code_q;
   assign err_cnt  = ecnt_q;
   assign seq_done = done_q;
   assign seq_cnt  = scnt_q;

endmodule

`default_nettype wire

// File: tb/tb_light_seq_checker.sv
// ============================================================================
//  Module   : tb_light_seq_checker
//  Purpose  : Self-checking bench for light_seq_checker. Two instances share
//             the lamp stimulus: a wide one (CNT_W=8) and a narrow one
//             (CNT_W=2) whose counters saturate at 3.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_light_seq_checker;

`ifdef LIGHT_CHK_HOLD_EN
   localparam bit HOLD_ON = 1'b1;
`else
   localparam bit HOLD_ON = 1'b0;
`endif

   typedef struct {
      logic [2:0] pat;
      logic       clr;
      logic       locked;
      logic       err;
      logic [1:0] code;
      logic [7:0] ecnt;
      logic       done;
      logic [7:0] scnt;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       red, amber, green, clr;

   logic       w_locked, w_err, w_done;
   logic [1:0] w_code;
   logic [7:0] w_ecnt, w_scnt;
   logic       n_locked, n_err, n_done;
   logic [1:0] n_code;
   logic [1:0] n_ecnt, n_scnt;

   int n_tests;
   int n_fail;

   vec_t tbl[$];
   vec_t sb[$];

   light_seq_checker #(.MAX_HOLD(0), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .red(red), .amber(amber), .green(green),
      .clr(clr), .locked(w_locked), .err(w_err), .err_code(w_code),
      .err_cnt(w_ecnt), .seq_done(w_done), .seq_cnt(w_scnt)
   );

   light_seq_checker #(.MAX_HOLD(0), .CNT_W(2)) u_dut_s (
      .clk(clk), .rst(rst), .red(red), .amber(amber), .green(green),
      .clr(clr), .locked(n_locked), .err(n_err), .err_code(n_code),
      .err_cnt(n_ecnt), .seq_done(n_done), .seq_cnt(n_scnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] sat3(input logic [7:0] x);
      return (x > 8'd3) ? 2'd3 : x[1:0];
   endfunction

   task automatic add(input logic [2:0] p, input logic c, input logic lk,
                      input logic e, input logic [1:0] cd, input logic [7:0] ec,
                      input logic dn, input logic [7:0] sc);
      vec_t v;
      v.pat = p; v.clr = c; v.locked = lk; v.err = e; v.code = cd;
      v.ecnt = ec; v.done = dn; v.scnt = sc;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input vec_t e);
      n_tests++;
      if (w_locked !== e.locked || w_err !== e.err || w_code !== e.code ||
          w_ecnt !== e.ecnt || w_done !== e.done || w_scnt !== e.scnt) begin
         n_fail++;
         $display("FAIL %s wide: got lk=%0b err=%0b code=%0b ec=%0d dn=%0b sc=%0d, want lk=%0b err=%0b code=%0b ec=%0d dn=%0b sc=%0d",
                  name, w_locked, w_err, w_code, w_ecnt, w_done, w_scnt,
                  e.locked, e.err, e.code, e.ecnt, e.done, e.scnt);
      end
      n_tests++;
      if (n_locked !== e.locked || n_err !== e.err || n_code !== e.code ||
          n_ecnt !== sat3(e.ecnt) || n_done !== e.done || n_scnt !== sat3(e.scnt)) begin
         n_fail++;
         $display("FAIL %s narrow: got lk=%0b err=%0b code=%0b ec=%0d dn=%0b sc=%0d, want lk=%0b err=%0b code=%0b ec=%0d dn=%0b sc=%0d",
                  name, n_locked, n_err, n_code, n_ecnt, n_done, n_scnt,
                  e.locked, e.err, e.code, sat3(e.ecnt), e.done, sat3(e.scnt));
      end
   endtask

   // Drive one sample between edges, queue its expectation, compare after
   // the edge that captures it
   task automatic step(input string name, input vec_t v);
      vec_t e;
      @(negedge clk);
      {red, amber, green} = v.pat;
      clr = v.clr;
      sb.push_back(v);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = sb.pop_front();
         check(name, e);
      end
   endtask

   task automatic step_h(input string name, input logic [2:0] p, input logic c,
                         input logic lk, input logic e, input logic [1:0] cd,
                         input logic [7:0] ec, input logic dn, input logic [7:0] sc);
      vec_t v;
      v.pat = p; v.clr = c; v.locked = lk; v.err = e; v.code = cd;
      v.ecnt = ec; v.done = dn; v.scnt = sc;
      step(name, v);
   endtask

   vec_t zero_v;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b0;
      {red, amber, green} = 3'b000;
      clr = 1'b0;
      zero_v = '{pat: 3'b000, clr: 1'b0, locked: 1'b0, err: 1'b0, code: 2'b00,
                 ecnt: 8'd0, done: 1'b0, scnt: 8'd0};

      // ---- stimulus table ----
      // three full sequences from reset; A->R pulses from the second R on
      for (int rep = 0; rep < 3; rep++) begin
         add(3'b100, 0, 1, 0, 0, 0, (rep > 0), 8'(rep));
         add(3'b110, 0, 1, 0, 0, 0, 0, 8'(rep));
         add(3'b001, 0, 1, 0, 0, 0, 0, 8'(rep));
         add(3'b010, 0, 1, 0, 0, 0, 0, 8'(rep));
      end
      add(3'b100, 0, 1, 0, 0, 0, 1, 3);
      // illegal pattern while locked, then relock on RA
      add(3'b111, 0, 0, 1, 1, 1, 0, 3);
      add(3'b110, 0, 1, 1, 1, 1, 0, 3);
      add(3'b001, 0, 1, 1, 1, 1, 0, 3);
      add(3'b010, 0, 1, 1, 1, 1, 0, 3);
      add(3'b100, 0, 1, 1, 1, 1, 1, 4);
      // clear, then skip RA for an illegal transition
      add(3'b110, 1, 1, 0, 0, 0, 0, 0);
      add(3'b001, 0, 1, 0, 0, 0, 0, 0);
      add(3'b010, 0, 1, 0, 0, 0, 0, 0);
      add(3'b100, 0, 1, 0, 0, 0, 1, 1);
      add(3'b001, 0, 1, 1, 2, 1, 0, 1);
      add(3'b010, 0, 1, 1, 2, 1, 0, 1);
      add(3'b111, 0, 0, 1, 2, 2, 0, 1);
      add(3'b010, 0, 1, 1, 2, 2, 0, 1);
      add(3'b100, 0, 1, 1, 2, 2, 1, 2);
      // clear, then five full sequences (narrow seq_cnt saturates at 3)
      add(3'b110, 1, 1, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 5; k++) begin
         add(3'b001, 0, 1, 0, 0, 0, 0, 8'(k - 1));
         add(3'b010, 0, 1, 0, 0, 0, 0, 8'(k - 1));
         add(3'b100, 0, 1, 0, 0, 0, 1, 8'(k));
         if (k < 5) add(3'b110, 0, 1, 0, 0, 0, 0, 8'(k));
      end
      // clear coincident with an illegal pattern: the error lands after clear
      add(3'b111, 1, 0, 1, 1, 1, 0, 0);
      // repeated illegal patterns while unsynchronised saturate narrow err_cnt
      add(3'b000, 0, 0, 1, 1, 2, 0, 0);
      add(3'b011, 0, 0, 1, 1, 3, 0, 0);
      add(3'b101, 0, 0, 1, 1, 4, 0, 0);
      add(3'b000, 0, 0, 1, 1, 5, 0, 0);

      // ---- reset state ----
      repeat (2) @(posedge clk);
      #1;
      check("reset", zero_v);
      #1;
      rst = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         step($sformatf("vec%0d", i), tbl[i]);
      end

      // ---- hold behaviour (MAX_HOLD = 0) ----
      step_h("hold_lock", 3'b100, 1, 1, 0, 0, 0, 0, 0);
      step_h("hold_1", 3'b100, 0, 1, HOLD_ON, HOLD_ON ? 2'b11 : 2'b00,
             HOLD_ON ? 8'd1 : 8'd0, 0, 0);
      step_h("hold_2", 3'b100, 0, 1, HOLD_ON, HOLD_ON ? 2'b11 : 2'b00,
             HOLD_ON ? 8'd2 : 8'd0, 0, 0);
      step_h("hold_bad", 3'b111, 0, 0, 1, HOLD_ON ? 2'b11 : 2'b01,
             HOLD_ON ? 8'd3 : 8'd1, 0, 0);
      step_h("hold_relock", 3'b110, 0, 1, 1, HOLD_ON ? 2'b11 : 2'b01,
             HOLD_ON ? 8'd3 : 8'd1, 0, 0);

      // ---- asynchronous reset between edges ----
      #3;
      rst = 1'b0;
      #1;
      check("async_rst", zero_v);
      {red, amber, green} = 3'b010;
      @(posedge clk);
      #1;
      check("rst_held", zero_v);
      #1;
      rst = 1'b1;
      step_h("post_rst_A", 3'b010, 0, 1, 0, 0, 0, 0, 0);
      step_h("post_rst_R", 3'b100, 0, 1, 0, 0, 0, 1, 1);
      step_h("post_rst_RA", 3'b110, 0, 1, 0, 0, 0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
